// File: rtl/intt_pkg.sv
// Shared constants, state/mode encodings and index helpers for the INTT controller.
package intt_pkg;

  localparam int LOG_N     = 12;
  localparam int ADDR_W    = 9;
  localparam int TWIDDLE_W = 10;
  localparam int LOG_M_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_FLUSH,
    ST_SWAP,
    ST_OUTPUT,
    ST_DONE
  } state_t;

  // Butterfly routing: first stage, wide-span stages, narrow-span stages.
  typedef enum logic [1:0] {
    MODE_FIRST = 2'd0,
    MODE_WIDE  = 2'd1,
    MODE_NARROW = 2'd2
  } mode_t;

  function automatic mode_t mode_of(input logic [LOG_M_W-1:0] log_m);
    if (log_m == LOG_M_W'(LOG_N)) return MODE_FIRST;
    else if (log_m >= 4'd6)       return MODE_WIDE;
    else                          return MODE_NARROW;
  endfunction

  // Twiddle index of the even (odd=0) or odd (odd=1) element of pair 'addr'.
  function automatic logic [TWIDDLE_W-1:0] twiddle_index(input logic [ADDR_W-1:0]  addr,
                                                         input logic               odd,
                                                         input logic [LOG_M_W-1:0] log_m);
    logic [TWIDDLE_W-1:0] pair;
    pair = {addr, odd};
    return pair >> (log_m - 4'd1);
  endfunction

endpackage

// File: rtl/intt_delay_line.sv
// Fixed-depth shift register that aligns core write strobes with read issue.
module intt_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every stage is reset, not just the head, so a mid-flight reset cannot leak a stale valid.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/intt_control.sv
// Sequencer for a bank of intt_core instances: load, log_n butterfly stages, unload.
module intt_control
  import intt_pkg::*;
#(
  parameter int LOG_CORE_COUNT = 4,
  parameter int PIPE_LATENCY   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done,
  output logic [LOG_M_W-1:0]   log_m,
  output logic [TWIDDLE_W-1:0] upper_i,
  output logic [TWIDDLE_W-1:0] lower_i,
  output logic [ADDR_W-1:0]    upper_read_address,
  output logic [ADDR_W-1:0]    lower_read_address,
  output logic [ADDR_W-1:0]    upper_write_address,
  output logic [ADDR_W-1:0]    lower_write_address,
  output logic                 write_enable,
  output logic                 write_select,
  output logic                 read_select,
  output logic                 input_select,
  output logic [1:0]           mode
);

  localparam int FLUSH_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = '1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(PIPE_LATENCY - 1);

  if (PIPE_LATENCY < 1 || LOG_CORE_COUNT < 0) begin : g_bad_params
    $error("intt_control: PIPE_LATENCY must be >= 1 and LOG_CORE_COUNT >= 0");
  end

  state_t               state;
  logic [ADDR_W-1:0]    addr;
  logic [LOG_M_W-1:0]   log_m_q;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic                 ws_q;
  logic                 ov_q;
  logic                 from_load;

  logic                 dl_valid;
  logic [ADDR_W-1:0]    dl_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      log_m_q   <= LOG_M_W'(LOG_N);
      flush_cnt <= '0;
      ws_q      <= 1'b1;
      ov_q      <= 1'b0;
      from_load <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LOAD;
            addr    <= '0;
            ws_q    <= 1'b1;
            log_m_q <= LOG_M_W'(LOG_N);
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (addr == ADDR_LAST) begin
              state     <= ST_SWAP;
              addr      <= '0;
              ws_q      <= ~ws_q;
              from_load <= 1'b1;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (addr == ADDR_LAST) begin
            state     <= ST_FLUSH;
            addr      <= '0;
            flush_cnt <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        ST_FLUSH: begin
          // The last write of the stage leaves the pipeline on the final flush cycle.
          if (flush_cnt == FLUSH_LAST) begin
            state <= ST_SWAP;
            ws_q  <= ~ws_q;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        ST_SWAP: begin
          from_load <= 1'b0;
          if (from_load) begin
            state <= ST_COMPUTE;
          end else if (log_m_q == 4'd1) begin
            state <= ST_OUTPUT;
            addr  <= '0;
            ov_q  <= 1'b0;
          end else begin
            state   <= ST_COMPUTE;
            log_m_q <= log_m_q - 1'b1;
          end
        end
        ST_OUTPUT: begin
          // addr names the word shown on the core outputs once ov_q is set.
          if (!ov_q) begin
            ov_q <= 1'b1;
          end else if (out_ready) begin
            if (addr == ADDR_LAST) begin
              state <= ST_DONE;
              addr  <= '0;
              ov_q  <= 1'b0;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          log_m_q <= LOG_M_W'(LOG_N);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  intt_delay_line #(
    .WIDTH (1 + ADDR_W),
    .DEPTH (PIPE_LATENCY)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d   ({state == ST_COMPUTE, addr}),
    .q   ({dl_valid, dl_addr})
  );

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    rd_addr      = '0;
    wr_addr      = '0;
    write_enable = 1'b0;
    upper_i      = '0;
    lower_i      = '0;
    unique case (state)
      ST_LOAD: begin
        write_enable = in_valid;
        wr_addr      = addr;
      end
      ST_COMPUTE: begin
        rd_addr      = addr;
        upper_i      = twiddle_index(addr, 1'b0, log_m_q);
        lower_i      = twiddle_index(addr, 1'b1, log_m_q);
        write_enable = dl_valid;
        wr_addr      = dl_valid ? dl_addr : '0;
      end
      ST_FLUSH: begin
        write_enable = dl_valid;
        wr_addr      = dl_valid ? dl_addr : '0;
      end
      ST_OUTPUT: begin
        // On an accept, the next word is requested in the same cycle so the core
        // outputs advance with no bubble; on a stall the shown word is re-read.
        rd_addr = (ov_q && out_ready && addr != ADDR_LAST) ? addr + 1'b1 : addr;
      end
      default: ;
    endcase
  end

  assign upper_read_address  = rd_addr;
  assign lower_read_address  = rd_addr;
  assign upper_write_address = wr_addr;
  assign lower_write_address = wr_addr;

  assign in_ready     = (state == ST_LOAD);
  assign input_select = (state == ST_LOAD);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign out_valid    = ov_q;
  assign log_m        = log_m_q;
  assign mode         = mode_of(log_m_q);
  assign write_select = ws_q;
  assign read_select  = ~ws_q;

endmodule

// File: doc/intt_control.md
INTT_CONTROL -- requirements
Module: intt_control

Interface
REQ-001 SHALL have parameter LOG_CORE_COUNT, default 4: log2 of the number of intt_core instances driven in parallel.
REQ-002 SHALL have parameter PIPE_LATENCY, default 6: core read-to-write latency in cycles.
REQ-003 SHALL use one clock and an asynchronous, active-high reset (clk, rst): clk in 1, rst in 1.
REQ-004 SHALL have ports, as name direction width meaning:
- start in 1: begin one transform.
- in_valid in 1: load-phase word present.
- in_ready out 1: controller accepts the load word.
- out_ready in 1: downstream accepts the result word.
- out_valid out 1: core r1..r4 outputs hold a result word.
- busy out 1: transform in progress.
- done out 1: one-cycle completion pulse.
- log_m out 4: current stage.
- upper_i out 10, lower_i out 10: twiddle indices.
- upper_read_address out 9, lower_read_address out 9: read addresses.
- upper_write_address out 9, lower_write_address out 9: write addresses.
- write_enable out 1: core BRAM write strobe.
- write_select out 1, read_select out 1: ping-pong bank selects.
- input_select out 1: 1 = core writes direct input.
- mode out 2: butterfly routing mode.

Function
REQ-005 SHALL implement states IDLE, LOAD, COMPUTE, FLUSH, SWAP, OUTPUT, DONE.
REQ-006 IDLE: start=1 -> LOAD; start is ignored in every other state.
REQ-007 LOAD: input_select=1, in_ready=1, write_enable=in_valid; write addresses (upper=lower) increment on each in_valid&in_ready from 0; the 512th accept -> SWAP (next: COMPUTE).
REQ-008 COMPUTE: log_m starts at 12 and decrements by 1 per stage down to 1; each stage issues read addresses 0..511, one per cycle, upper=lower, with no stall.
REQ-009 mode SHALL be 0 when log_m=12, 1 when 6<=log_m<=11, and 2 when 1<=log_m<=5.
REQ-010 For read address a: upper_i = ({a,1'b0} >> (log_m-1)) and lower_i = ({a,1'b1} >> (log_m-1)), each truncated to 10 bits.
REQ-011 write_enable and the write addresses SHALL equal the issued read-valid and read addresses delayed by exactly PIPE_LATENCY cycles.
REQ-012 After the last read of a stage -> FLUSH for PIPE_LATENCY cycles until the last write completes, then -> SWAP.
REQ-013 SWAP: one cycle; toggles write_select and read_select; read_select SHALL always equal ~write_select; next state is COMPUTE (next log_m) or, after the log_m=1 stage, OUTPUT.
REQ-014 OUTPUT: read addresses 0..511; out_valid is asserted one cycle after each address is issued; while out_valid=1 and out_ready=0, the address and out_valid SHALL hold; the last accept -> DONE.
REQ-015 DONE: done=1 for one cycle, then -> IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 write_enable SHALL be 0 in OUTPUT, SWAP and IDLE.
REQ-018 Address counters SHALL wrap 511->0 only at a phase end, never mid-phase.

Reset
REQ-019 rst=1 SHALL force IDLE asynchronously, including when asserted mid-transform.
REQ-020 Reset values: log_m=12, mode=0, write_select=1, read_select=0, and every other output 0.
REQ-021 The delay pipeline SHALL be cleared on reset, so no stale write_enable is emitted afterwards.

Structure
REQ-022 Package intt_pkg SHALL hold LOG_N=12, ADDR_W=9, TWIDDLE_W=10, the state enumeration and the mode encoding.
REQ-023 The single sub-module intt_delay_line SHALL be parameterised by width and depth and SHALL carry the valid bit and addresses over PIPE_LATENCY cycles.

Verification
REQ-024 Reset then start with in_valid held high -> in_ready high for 512 cycles, write addresses 0..511, input_select=1, then SWAP with write_select=0, read_select=1.
REQ-025 Stage log_m=12, address 1 -> upper_i=0, lower_i=0, mode=0; at log_m=1, address 3 -> upper_i=6, lower_i=7, mode=2.
REQ-026 Read address 5 issued at cycle t -> write_enable=1 with write address 5 at cycle t+6.
REQ-027 OUTPUT with out_ready low for 3 cycles at address 10 -> address 10 and out_valid held 3 cycles; after 512 accepts, done pulses once, then busy=0.
REQ-028 rst asserted during stage log_m=7 -> outputs take reset values immediately; a new start completes a full transform.
REQ-029 start asserted while busy -> no effect on state or counters.
